// File: rtl/lm80c_kbd_pkg.sv
// Shared types and constants for the lm80c PS/2 keyboard front end.
package lm80c_kbd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDecode,
    StLookup,
    StApply
  } kbd_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } keymap_entry_t;

  function automatic keymap_entry_t key_at(input logic [2:0] r, input logic [2:0] c);
    keymap_entry_t e;
    e.valid = 1'b1;
    e.row   = r;
    e.col   = c;
    return e;
  endfunction

  // Bytes that neither prefix nor name a key: they cancel any pending prefix.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == PS2_PAUSE) || (code == PS2_BAT) || (code == PS2_ACK) || (code == PS2_ECHO);
  endfunction

endpackage

// File: rtl/lm80c_keymap.sv
// Registered 512x7 keymap ROM: {ext, scancode} -> {valid, row, col} of the lm80c matrix.
module lm80c_keymap
  import lm80c_kbd_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [8:0]    i_addr,
  output keymap_entry_t o_entry
);

  keymap_entry_t w_entry;
  keymap_entry_t r_entry;

  always_comb begin
    w_entry = '0;
    case (i_addr)
      9'h01C:  w_entry = key_at(3'd1, 3'd2);  // A
      9'h032:  w_entry = key_at(3'd3, 3'd4);  // B
      9'h021:  w_entry = key_at(3'd2, 3'd4);  // C
      9'h023:  w_entry = key_at(3'd2, 3'd2);  // D
      9'h05A:  w_entry = key_at(3'd0, 3'd7);  // Enter
      9'h012:  w_entry = key_at(3'd6, 3'd0);  // LShift
      9'h029:  w_entry = key_at(3'd7, 3'd4);  // Space
      9'h066:  w_entry = key_at(3'd0, 3'd0);  // Backspace
      9'h175:  w_entry = key_at(3'd7, 3'd3);  // Up
      9'h172:  w_entry = key_at(3'd7, 3'd5);  // Down
      default: w_entry = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_entry <= '0;
    else          r_entry <= w_entry;
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/lm80c_keyboard.sv
// PS/2 set-2 receiver and decoder driving the lm80c 8x8 active-low key matrix.
module lm80c_keyboard
  import lm80c_kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clear_all,
  output logic [7:0] KM [7:0],
  output logic       key_strobe,
  output logic [7:0] last_code,
  output logic       parity_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   w_clk_s, w_dat_s;
  logic                   r_clk_filt, r_fall, r_fall_data;
  logic [FiltW-1:0]       r_filt_cnt;
  kbd_state_e             r_state, w_state_d;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift, r_last_code;
  logic                   r_parity, r_ext, r_brk, r_parity_err;
  logic [WdW-1:0]         r_wd;
  logic [7:0]             r_km [7:0];
  keymap_entry_t          w_entry;
  logic                   w_timeout, w_parity_err, w_set_ext, w_set_brk, w_clr_flags, w_write;

  // Assert asynchronously, release synchronously.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge sys_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end
  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // A new clock level is accepted after FILTER_LEN consecutive differing samples.
  always_ff @(posedge sys_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_clk_filt  <= 1'b1;
      r_filt_cnt  <= '0;
      r_fall      <= 1'b0;
      r_fall_data <= 1'b1;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltW'(FILTER_LEN - 1)) begin
        r_clk_filt  <= w_clk_s;
        r_filt_cnt  <= '0;
        r_fall      <= ~w_clk_s;
        r_fall_data <= w_dat_s;
      end else begin
        r_filt_cnt <= r_filt_cnt + FiltW'(1);
      end
    end
  end

  lm80c_keymap u_keymap (
    .i_clk   (sys_clock),
    .i_rst_n (w_rst_n),
    .i_addr  ({r_ext, r_shift}),
    .o_entry (w_entry)
  );

  assign w_timeout = (r_state != StIdle) && !r_fall && (r_wd == WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d    = r_state;
    w_parity_err = 1'b0;
    w_set_ext    = 1'b0;
    w_set_brk    = 1'b0;
    w_clr_flags  = 1'b0;
    w_write      = 1'b0;
    unique case (r_state)
      StIdle:   if (r_fall && !r_fall_data) w_state_d = StData;
      StData:   if (r_fall && (r_bit_cnt == 3'd7)) w_state_d = StParity;
      StParity: if (r_fall) w_state_d = StStop;
      StStop: begin
        if (r_fall) begin
          if (r_fall_data && (^r_shift ^ r_parity)) begin
            w_state_d = StDecode;
          end else begin
            w_state_d    = StIdle;
            w_parity_err = 1'b1;
          end
        end
      end
      StDecode: begin
        w_state_d = StIdle;
        if (r_shift == PS2_EXT)      w_set_ext   = 1'b1;
        else if (r_shift == PS2_BRK) w_set_brk   = 1'b1;
        else if (is_ignored(r_shift)) w_clr_flags = 1'b1;
        else                          w_state_d   = StLookup;
      end
      StLookup: w_state_d = StApply;
      StApply: begin
        w_write     = w_entry.valid;
        w_clr_flags = 1'b1;
        w_state_d   = StIdle;
      end
      default:  w_state_d = StIdle;
    endcase
    if (w_timeout) w_state_d = StIdle;
  end

  always_ff @(posedge sys_clock or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge sys_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_wd         <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_last_code  <= '0;
      r_parity_err <= 1'b0;
      for (int i = 0; i < 8; i++) r_km[i] <= 8'hFF;
    end else begin
      r_parity_err <= w_parity_err;
      if ((r_state == StIdle) || r_fall) r_wd <= '0;
      else                               r_wd <= r_wd + WdW'(1);
      if (r_state == StIdle) begin
        r_bit_cnt <= '0;
      end else if ((r_state == StData) && r_fall) begin
        r_shift   <= {r_fall_data, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == StParity) && r_fall) r_parity <= r_fall_data;
      if (r_state == StDecode) r_last_code <= r_shift;
      if (w_set_ext) r_ext <= 1'b1;
      if (w_set_brk) r_brk <= 1'b1;
      if (clear_all || w_clr_flags) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
      if (clear_all) begin
        for (int i = 0; i < 8; i++) r_km[i] <= 8'hFF;
      end else if (w_write) begin
        r_km[w_entry.row][w_entry.col] <= r_brk;
      end
    end
  end

  assign KM         = r_km;
  assign key_strobe = w_write | clear_all;
  assign last_code  = r_last_code;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_lm80c_keyboard.sv
// Self-checking bench: PS/2 frames driven bit by bit, matrix checked against a scancode-level model.
`timescale 1ns/1ps
module tb_lm80c_keyboard;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned TIMEOUT_CYCLES = 16384;
  localparam int unsigned FILTER_LEN     = 8;
  localparam int          HALF           = 16;
  localparam int          LAT_BOUND      = SYNC_STAGES + FILTER_LEN + 6;

  logic       sys_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       clear_all = 1'b0;
  logic [7:0] KM [7:0];
  logic       key_strobe, parity_err;
  logic [7:0] last_code;

  lm80c_keyboard #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clear_all  (clear_all),
    .KM         (KM),
    .key_strobe (key_strobe),
    .last_code  (last_code),
    .parity_err (parity_err)
  );

  always #5 sys_clock = ~sys_clock;

  int  n_checks = 0;
  int  n_errors = 0;
  int  strobe_cnt = 0;
  int  perr_cnt = 0;
  time t_stop_fall = 0;
  time t_last_strobe = 0;

  always @(negedge sys_clock) begin
    if (key_strobe) begin
      strobe_cnt++;
      t_last_strobe = $time;
    end
    if (parity_err) perr_cnt++;
  end

  // Reference model: scancode stream -> matrix, written from the keymap table.
  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         row;
    int         col;
  } key_t;

  key_t       keys[$];
  logic [7:0] m_km [8];
  bit         m_ext, m_brk;
  logic [7:0] m_last;
  int         m_strobes = 0;
  int         m_perrs = 0;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_km[i] = 8'hFF;
    m_ext  = 0;
    m_brk  = 0;
    m_last = 8'h00;
  endfunction

  function automatic bit model_lookup(input bit ext, input logic [7:0] code,
                                      output int row, output int col);
    row = 0;
    col = 0;
    foreach (keys[i]) begin
      if (keys[i].ext == ext && keys[i].code == code) begin
        row = keys[i].row;
        col = keys[i].col;
        return 1;
      end
    end
    return 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int r, c;
    m_last = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hEE) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      if (model_lookup(m_ext, b, r, c)) begin
        m_km[r][c] = m_brk;
        m_strobes++;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic logic [63:0] dut_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = KM[i];
    return f;
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_km[i];
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge sys_clock);
      ps2_clk = 1'b0;
      t_stop_fall = $time;
      repeat (HALF) @(negedge sys_clock);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11);
    repeat (5) @(negedge sys_clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic test_reset();
    n_checks++;
    if (dut_flat() !== {64{1'b1}}) begin
      n_errors++; $display("FAIL reset_km: got %h expected %h", dut_flat(), {64{1'b1}});
    end
    n_checks++;
    if (key_strobe !== 1'b0) begin
      n_errors++; $display("FAIL reset_strobe: got %b expected 0", key_strobe);
    end
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_perr: got %b expected 0", parity_err);
    end
    n_checks++;
    if (last_code !== 8'h00) begin
      n_errors++; $display("FAIL reset_last: got %h expected 00", last_code);
    end
  endtask

  task automatic test_press_release();
    int  s0 = strobe_cnt;
    time lat;
    send_byte(8'h1C);
    n_checks++;
    if (KM[1] !== 8'hFB) begin
      n_errors++; $display("FAIL a_press: got %h expected fb", KM[1]);
    end
    n_checks++;
    if (strobe_cnt - s0 != 1) begin
      n_errors++; $display("FAIL a_strobe_count: got %0d expected 1", strobe_cnt - s0);
    end
    n_checks++;
    if (last_code !== 8'h1C) begin
      n_errors++; $display("FAIL a_last: got %h expected 1c", last_code);
    end
    lat = (t_last_strobe - t_stop_fall) / 10;
    n_checks++;
    if (t_last_strobe <= t_stop_fall || lat > LAT_BOUND) begin
      n_errors++; $display("FAIL a_latency: got %0d cycles expected <= %0d", lat, LAT_BOUND);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (KM[1] !== 8'hFF) begin
      n_errors++; $display("FAIL a_release: got %h expected ff", KM[1]);
    end
  endtask

  task automatic test_combo();
    send_byte(8'h12);
    send_byte(8'h1C);
    n_checks++;
    if (KM[6] !== 8'hFE || KM[1] !== 8'hFB) begin
      n_errors++; $display("FAIL combo_press: got %h/%h expected fe/fb", KM[6], KM[1]);
    end
    send_byte(8'hF0);
    send_byte(8'h12);
    n_checks++;
    if (KM[6] !== 8'hFF || KM[1] !== 8'hFB) begin
      n_errors++; $display("FAIL combo_release: got %h/%h expected ff/fb", KM[6], KM[1]);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (dut_flat() !== model_flat()) begin
      n_errors++; $display("FAIL combo_model: got %h expected %h", dut_flat(), model_flat());
    end
  endtask

  task automatic test_ext();
    int s0;
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if (KM[7] !== 8'hF7) begin
      n_errors++; $display("FAIL up_press: got %h expected f7", KM[7]);
    end
    s0 = strobe_cnt;
    send_byte(8'h75);
    n_checks++;
    if (dut_flat() !== model_flat() || strobe_cnt != s0) begin
      n_errors++; $display("FAIL bare_75: got %h strobes %0d expected %h strobes 0",
                           dut_flat(), strobe_cnt - s0, model_flat());
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if (KM[7] !== 8'hFF) begin
      n_errors++; $display("FAIL up_release: got %h expected ff", KM[7]);
    end
  endtask

  task automatic test_parity();
    int p0 = perr_cnt;
    send_frame(8'h5A, 1'b1);
    m_perrs++;
    n_checks++;
    if (perr_cnt - p0 != 1) begin
      n_errors++; $display("FAIL perr_pulse: got %0d expected 1", perr_cnt - p0);
    end
    n_checks++;
    if (KM[0] !== 8'hFF) begin
      n_errors++; $display("FAIL perr_km: got %h expected ff", KM[0]);
    end
    send_byte(8'h5A);
    n_checks++;
    if (KM[0] !== 8'h7F) begin
      n_errors++; $display("FAIL enter_press: got %h expected 7f", KM[0]);
    end
  endtask

  task automatic test_timeout();
    int p0 = perr_cnt;
    send_bits({6'b0, 4'hA, 1'b0}, 5);
    repeat (TIMEOUT_CYCLES + 100) @(negedge sys_clock);
    send_byte(8'h1C);
    n_checks++;
    if (KM[1] !== 8'hFB || last_code !== 8'h1C) begin
      n_errors++; $display("FAIL timeout_recover: got %h/%h expected fb/1c", KM[1], last_code);
    end
    n_checks++;
    if (perr_cnt != p0) begin
      n_errors++; $display("FAIL timeout_perr: got %0d expected 0", perr_cnt - p0);
    end
  endtask

  task automatic test_clear_apply();
    bit seen = 0;
    n_checks++;
    if (KM[1] !== 8'hFB || KM[0] !== 8'h7F) begin
      n_errors++; $display("FAIL clear_setup: got %h/%h expected fb/7f", KM[1], KM[0]);
    end
    fork
      send_frame(8'h12, 1'b0);
      begin
        int k = 0;
        while (!key_strobe && k < 1000) begin
          @(negedge sys_clock);
          k++;
        end
        if (key_strobe) begin
          seen = 1;
          clear_all = 1'b1;
          @(negedge sys_clock);
          clear_all = 1'b0;
        end
      end
    join
    model_reset();
    m_last = 8'h12;
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL clear_apply_strobe: got no strobe expected one");
    end
    n_checks++;
    if (dut_flat() !== {64{1'b1}}) begin
      n_errors++; $display("FAIL clear_apply_km: got %h expected %h", dut_flat(), {64{1'b1}});
    end
    n_checks++;
    if (last_code !== 8'h12) begin
      n_errors++; $display("FAIL clear_apply_last: got %h expected 12", last_code);
    end
  endtask

  task automatic test_random();
    for (int ev = 0; ev < 30; ev++) begin
      int         s0 = strobe_cnt;
      int         p0 = perr_cnt;
      int         e0 = m_strobes;
      int         ep0 = m_perrs;
      int         kind = $urandom_range(0, 5);
      int         k = $urandom_range(0, keys.size() - 1);
      int         r, c;
      logic [7:0] u;
      case (kind)
        0, 1: begin
          if (keys[k].ext) send_byte(8'hE0);
          send_byte(keys[k].code);
        end
        2: begin
          if (keys[k].ext) send_byte(8'hE0);
          send_byte(8'hF0);
          send_byte(keys[k].code);
        end
        3: begin
          do u = 8'($urandom_range(0, 255));
          while (u == 8'hE0 || u == 8'hF0 || u == 8'hE1 || u == 8'hAA || u == 8'hFA ||
                 u == 8'hEE || model_lookup(m_ext, u, r, c));
          send_byte(u);
        end
        4: begin
          case ($urandom_range(0, 3))
            0:       u = 8'hAA;
            1:       u = 8'hFA;
            2:       u = 8'hEE;
            default: u = 8'hE1;
          endcase
          send_byte(u);
        end
        default: begin
          send_frame(8'($urandom_range(0, 255)), 1'b1);
          m_perrs++;
        end
      endcase
      n_checks++;
      if (dut_flat() !== model_flat()) begin
        n_errors++; $display("FAIL rnd_km ev%0d: got %h expected %h", ev, dut_flat(), model_flat());
      end
      n_checks++;
      if (last_code !== m_last) begin
        n_errors++; $display("FAIL rnd_last ev%0d: got %h expected %h", ev, last_code, m_last);
      end
      n_checks++;
      if (strobe_cnt - s0 != m_strobes - e0) begin
        n_errors++; $display("FAIL rnd_strobe ev%0d: got %0d expected %0d",
                             ev, strobe_cnt - s0, m_strobes - e0);
      end
      n_checks++;
      if (perr_cnt - p0 != m_perrs - ep0) begin
        n_errors++; $display("FAIL rnd_perr ev%0d: got %0d expected %0d",
                             ev, perr_cnt - p0, m_perrs - ep0);
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h1C);
    n_checks++;
    if (KM[1] !== m_km[1]) begin
      n_errors++; $display("FAIL mid_setup: got %h expected %h", KM[1], m_km[1]);
    end
    send_bits({7'b0, 3'b101, 1'b0}, 4);
    @(negedge sys_clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_flat() !== {64{1'b1}}) begin
      n_errors++; $display("FAIL mid_reset_km: got %h expected %h", dut_flat(), {64{1'b1}});
    end
    n_checks++;
    if (last_code !== 8'h00) begin
      n_errors++; $display("FAIL mid_reset_last: got %h expected 00", last_code);
    end
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (5) @(negedge sys_clock);
    model_reset();
    send_byte(8'h5A);
    n_checks++;
    if (KM[0] !== 8'h7F || dut_flat() !== model_flat()) begin
      n_errors++; $display("FAIL mid_after: got %h expected %h", dut_flat(), model_flat());
    end
  endtask

  initial begin
    keys.push_back('{0, 8'h1C, 1, 2});
    keys.push_back('{0, 8'h32, 3, 4});
    keys.push_back('{0, 8'h21, 2, 4});
    keys.push_back('{0, 8'h23, 2, 2});
    keys.push_back('{0, 8'h5A, 0, 7});
    keys.push_back('{0, 8'h12, 6, 0});
    keys.push_back('{0, 8'h29, 7, 4});
    keys.push_back('{0, 8'h66, 0, 0});
    keys.push_back('{1, 8'h75, 7, 3});
    keys.push_back('{1, 8'h72, 7, 5});
    model_reset();
    repeat (4) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (5) @(negedge sys_clock);
    test_reset();
    test_press_release();
    test_combo();
    test_ext();
    test_parity();
    test_timeout();
    test_clear_apply();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
